io_handshake_controller: RTL and testbench

Sequencer between the processor core and the board I/O: it services the CPU's IN instruction by stalling the core until the operator sets the 8 switches and presses the key. It then returns the switch value, and it latches the CPU's OUT values for the display module. It owns key synchronisation and debouncing, and guarantees one key press feeds exactly one IN instruction. It sits in the system top between the processor and the display/switch hardware, and drives the display module's "waiting for input" control.

---
 rtl/io_handshake_controller.sv | 92 +++++++++
 tb/tb_io_handshake_controller.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/io_handshake_controller.sv
// io_handshake_controller: stalls the CPU on IN until a debounced key press, latches OUT values for the display
// Ports: realClk/rst (sync, active-high); chave raw active-low key; dadosIN switches;
//   in_req/in_data/in_valid/cpu_stall for the IN instruction; out_req/out_data -> disp_data/disp_load;
//   aguardando_entrada high while waiting for the key.
module io_handshake_controller #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        realClk,
  input  logic        rst,
  input  logic        chave,
  input  logic [7:0]  dadosIN,
  input  logic        in_req,
  output logic [31:0] in_data,
  output logic        in_valid,
  output logic        cpu_stall,
  input  logic        out_req,
  input  logic [31:0] out_data,
  output logic [31:0] disp_data,
  output logic        disp_load,
  output logic        aguardando_entrada
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, WAIT_PRESS = 2'd1, WAIT_RELEASE = 2'd2;
  logic          sync1_q, sync2_q, db_q, db_d, db_prev_q, press;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic [31:0]   in_data_q, in_data_d, disp_data_q, disp_data_d;
  logic          in_valid_q, in_valid_d, disp_load_q, disp_load_d;
  always_ff @(posedge realClk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      db_q        <= 1'b1;
      db_prev_q   <= 1'b1;
      cnt_q       <= '0;
      state_q     <= IDLE;
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
      disp_data_q <= '0;
      disp_load_q <= 1'b0;
    end else begin
      sync1_q     <= chave;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      db_prev_q   <= db_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      in_data_q   <= in_data_d;
      in_valid_q  <= in_valid_d;
      disp_data_q <= disp_data_d;
      disp_load_q <= disp_load_d;
    end
  end
  // Counter runs only while the sample disagrees with db; the DEBOUNCE_CYCLES-th disagreement flips db.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = ~db_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  assign press = db_prev_q & ~db_q;
  always_comb begin
    state_d     = state_q;
    in_valid_d  = 1'b0;
    in_data_d   = in_data_q;
    disp_data_d = out_req ? out_data : disp_data_q;
    disp_load_d = out_req;
    case (state_q)
      IDLE:         state_d = in_req ? WAIT_PRESS : IDLE;
      WAIT_PRESS: begin
        if (!in_req) state_d = IDLE;
        else if (press) begin
          state_d    = WAIT_RELEASE;
          in_valid_d = 1'b1;
          in_data_d  = {24'b0, dadosIN};
        end
      end
      WAIT_RELEASE: state_d = db_q ? IDLE : WAIT_RELEASE;
      default:      state_d = IDLE;
    endcase
  end
  always_comb begin
    aguardando_entrada = state_q == WAIT_PRESS;
    cpu_stall          = ~rst & in_req & ~in_valid_q;
    in_data            = in_data_q;
    in_valid           = in_valid_q;
    disp_data          = disp_data_q;
    disp_load          = disp_load_q;
  end
endmodule

// File: tb/tb_io_handshake_controller.sv
// tb_io_handshake_controller: directed self-checking bench for io_handshake_controller
module tb_io_handshake_controller;
  logic        realClk = 1'b0, rst = 1'b1, chave = 1'b1, in_req = 1'b0, out_req = 1'b0;
  logic [7:0]  dadosIN = '0;
  logic [31:0] out_data = '0, in_data, disp_data;
  logic        in_valid, cpu_stall, disp_load, aguardando_entrada;
  int          n_tests = 0, n_fail = 0;
  io_handshake_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .realClk(realClk), .rst(rst), .chave(chave), .dadosIN(dadosIN),
    .in_req(in_req), .in_data(in_data), .in_valid(in_valid), .cpu_stall(cpu_stall),
    .out_req(out_req), .out_data(out_data), .disp_data(disp_data), .disp_load(disp_load),
    .aguardando_entrada(aguardando_entrada)
  );
  always #5 realClk = ~realClk;
  task automatic tick();
    @(posedge realClk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_in(input logic [7:0] dv, input string tag);
    dadosIN = dv;
    chave   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check({tag, "_valid"}, 32'(in_valid), 32'(i == 6));
      check({tag, "_stall"}, 32'(cpu_stall), 32'(i != 6));
    end
    check({tag, "_data"}, in_data, {24'b0, dv});
    in_req = 1'b0;
    tick();
    check({tag, "_valid_drop"}, 32'(in_valid), 32'd0);
    check({tag, "_state_rel"}, 32'(dut.state_q), 32'd2);
  endtask
  task automatic release_key();
    chave = 1'b1;
    for (int i = 0; i < 10; i++) tick();
  endtask
  initial begin
    rst = 1'b1;
    in_req = 1'b1;
    tick();
    tick();
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_valid", 32'(in_valid), 32'd0);
    check("rst_load", 32'(disp_load), 32'd0);
    check("rst_wait", 32'(aguardando_entrada), 32'd0);
    check("rst_in_data", in_data, 32'd0);
    check("rst_disp_data", disp_data, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);
    check("rst_db", 32'(dut.db_q), 32'd1);
    rst = 1'b0;
    in_req = 1'b0;
    tick();
    in_req = 1'b1;
    tick();
    check("idle_to_wait", 32'(aguardando_entrada), 32'd1);
    check("wait_stall", 32'(cpu_stall), 32'd1);
    do_in(8'hA5, "basic");
    in_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("held_valid", 32'(in_valid), 32'd0);
      check("held_stall", 32'(cpu_stall), 32'd1);
    end
    chave = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_rel_valid", 32'(in_valid), 32'd0);
    end
    check("held_rel_state", 32'(dut.state_q), 32'd1);
    check("held_rel_wait", 32'(aguardando_entrada), 32'd1);
    do_in(8'h3C, "second");
    release_key();
    check("back_idle", 32'(dut.state_q), 32'd0);
    in_req = 1'b1;
    tick();
    chave = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chave = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_valid", 32'(in_valid), 32'd0);
      check("glitch_db", 32'(dut.db_q), 32'd1);
    end
    check("glitch_stall", 32'(cpu_stall), 32'd1);
    do_in(8'h5A, "after_glitch");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("after_glitch_once", 32'(in_valid), 32'd0);
    end
    release_key();
    in_req = 1'b1;
    tick();
    out_req = 1'b1;
    out_data = 32'h1234ABCD;
    tick();
    check("out1_load", 32'(disp_load), 32'd1);
    check("out1_data", disp_data, 32'h1234ABCD);
    check("out1_stall", 32'(cpu_stall), 32'd1);
    out_data = 32'h00000007;
    tick();
    check("out2_load", 32'(disp_load), 32'd1);
    check("out2_data", disp_data, 32'h00000007);
    out_req = 1'b0;
    tick();
    check("out_load_off", 32'(disp_load), 32'd0);
    check("out_data_hold", disp_data, 32'h00000007);
    check("out_stall", 32'(cpu_stall), 32'd1);
    check("out_wait", 32'(aguardando_entrada), 32'd1);
    in_req = 1'b0;
    tick();
    check("abort_state", 32'(dut.state_q), 32'd0);
    check("abort_wait", 32'(aguardando_entrada), 32'd0);
    check("abort_stall", 32'(cpu_stall), 32'd0);
    chave = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort_press_valid", 32'(in_valid), 32'd0);
    end
    release_key();
    in_req = 1'b1;
    tick();
    do_in(8'hC3, "pre_reset");
    rst = 1'b1;
    in_req = 1'b1;
    tick();
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    rst = 1'b0;
    in_req = 1'b0;
    chave = 1'b1;
    check("mid_rst_state", 32'(dut.state_q), 32'd0);
    check("mid_rst_db", 32'(dut.db_q), 32'd1);
    check("mid_rst_in_data", in_data, 32'd0);
    check("mid_rst_disp", disp_data, 32'd0);
    check("mid_rst_valid", 32'(in_valid), 32'd0);
    check("mid_rst_wait", 32'(aguardando_entrada), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
